gate_scan_ctrl: RTL and testbench

// Bus-master sequencer for the gate register block. It steps the gate number

---
 rtl/gate_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_gate_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_scan_ctrl.sv
// gate_scan_ctrl: bus master that steps the gate register through 1..N_GATES,
// confirms each write by readback, dwells on accepted gates and parks at 0.
module gate_scan_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] GATE_ADDR   = 8'h22,
  parameter int                    N_GATES     = 10,
  parameter int                    DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [N_GATES-1:0]     mask,
  output logic [DATA_WIDTH-1:0]  bus_addr,
  output logic [DATA_WIDTH-1:0]  bus_wdata,
  output logic                   bus_we,
  input  logic [DATA_WIDTH-1:0]  bus_rdata,
  output logic [3:0]             gate_cur,
  output logic                   gate_valid,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             err_cnt
);

  typedef enum logic [3:0] {
    IDLE, SEEK, WRITE, WAIT1, WAIT2, CHECK, DWELL, PARK, PDONE
  } state_t;

  localparam logic [4:0]             LAST_GATE = 5'(N_GATES);
  localparam logic [3:0]             LAST_SEEK = 4'(N_GATES - 1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [4:0]             cand_q, cand_d;
  logic [3:0]             seek_q, seek_d;
  logic [3:0]             gate_q, gate_d;
  logic [7:0]             err_q, err_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [4:0]             cand_eff;
  logic                   cand_msk;
  logic                   cand_wrap;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DWELL_WIDTH-1:0] dwell_min1(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? DWELL_ONE : d;
  endfunction

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cand_q  <= 5'd1;
      seek_q  <= '0;
      gate_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      seek_q  <= seek_d;
      gate_q  <= gate_d;
      err_q   <= err_d;
    end
  end

  // dwell counter is pure datapath: always loaded in CHECK before DWELL reads it
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    seek_d    = seek_q;
    gate_d    = gate_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cand_wrap = (cand_q > LAST_GATE);
    cand_eff  = cand_wrap ? 5'd1 : cand_q;
    cand_msk  = 1'b0;
    for (int i = 0; i < N_GATES; i++) begin
      if (cand_eff == 5'(i + 1)) cand_msk = mask[i];
    end

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = SEEK;
          cand_d  = 5'd1;
          seek_d  = '0;
        end
      end
      SEEK: begin
        if (cand_wrap && !loop) begin
          state_d = PARK;
        end else if (!cand_msk) begin
          state_d = WRITE;
          gate_d  = cand_eff[3:0];
        end else if (seek_q == LAST_SEEK) begin
          // every gate has been looked at once: nothing left to scan
          state_d = PARK;
        end else begin
          cand_d = cand_eff + 5'd1;
          seek_d = seek_q + 4'd1;
        end
      end
      WRITE: state_d = WAIT1;
      WAIT1: state_d = WAIT2;
      WAIT2: state_d = CHECK;
      CHECK: begin
        if (bus_rdata == DATA_WIDTH'(gate_q)) begin
          state_d = DWELL;
          cnt_d   = dwell_min1(dwell);
        end else begin
          state_d = SEEK;
          err_d   = sat_inc(err_q);
          cand_d  = {1'b0, gate_q} + 5'd1;
          seek_d  = '0;
        end
      end
      DWELL: begin
        if (cnt_q <= DWELL_ONE) begin
          state_d = SEEK;
          cand_d  = {1'b0, gate_q} + 5'd1;
          seek_d  = '0;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      PARK:    state_d = PDONE;
      PDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (stop && (state_q inside {SEEK, WRITE, WAIT1, WAIT2, CHECK, DWELL})) begin
      state_d = PARK;
    end
    if (state_d == PARK) gate_d = '0;
  end

  assign bus_we     = (state_q == WRITE) || (state_q == PARK);
  assign bus_addr   = (state_q == IDLE) ? '0 : GATE_ADDR;
  assign bus_wdata  = (state_q == WRITE) ? DATA_WIDTH'(gate_q) : '0;
  assign gate_cur   = gate_q;
  assign gate_valid = (state_q == DWELL);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == PDONE);
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_gate_scan_ctrl.sv
// Bench for gate_scan_ctrl: gate-block model, write/dwell scoreboard,
// table of scan vectors and hand-written stop/loop/saturation/reset sequences.
module tb_gate_scan_ctrl;
  localparam int DW = 8;
  localparam int NG = 10;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [WW-1:0] dwell = '0;
  logic [NG-1:0] mask = '0;
  logic [DW-1:0] bus_addr, bus_wdata, bus_rdata;
  logic          bus_we;
  logic [3:0]    gate_cur;
  logic          gate_valid, busy, done;
  logic [7:0]    err_cnt;

  gate_scan_ctrl #(.DATA_WIDTH(DW), .GATE_ADDR(8'h22), .N_GATES(NG), .DWELL_WIDTH(WW)) dut (
    .clk(clk), .res_n(res_n), .start(start), .stop(stop), .loop(loop),
    .dwell(dwell), .mask(mask), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rdata(bus_rdata), .gate_cur(gate_cur),
    .gate_valid(gate_valid), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // gate block: 1-cycle register update, 1-cycle registered read; rejected gates store 0
  logic [15:0] reject = '0;
  logic [7:0]  gate_reg = '0;
  logic [7:0]  rd_q = '0;
  always @(posedge clk) begin
    if (bus_we && bus_addr == 8'h22) gate_reg <= reject[bus_wdata[3:0]] ? 8'h00 : bus_wdata;
    rd_q <= gate_reg;
  end
  assign bus_rdata = rd_q;

  typedef struct { logic [3:0] g; int len; } run_t;
  typedef struct {
    logic [9:0]  mask;
    logic [15:0] dwell;
    logic [15:0] reject;
    logic [39:0] seq;
    int          nseq;
    int          err_inc;
    int          lat;
  } vec_t;

  logic [7:0] exp_wr[$];
  run_t       exp_run[$];
  vec_t       vecs[6];
  int         checks = 0;
  int         errors = 0;
  bit         sb_en = 1'b1;
  int         run_len = 0;
  logic [3:0] run_gate = '0;
  int         done_cnt = 0;
  int         n_wr = 0;
  int         exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    logic [7:0] e;
    run_t r;
    @(negedge clk);
    if (bus_we) begin
      n_wr++;
      if (sb_en) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got data %0h, no write expected", bus_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("write_data", {24'h0, bus_wdata}, {24'h0, e});
          chk("write_addr", {24'h0, bus_addr}, 32'h22);
        end
      end
    end
    if (gate_valid) begin
      if (run_len == 0) run_gate = gate_cur;
      run_len++;
    end else if (run_len > 0) begin
      if (exp_run.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_run: got gate %0d len %0d, none expected", run_gate, run_len);
      end else begin
        r = exp_run.pop_front();
        chk("run_gate", {28'h0, run_gate}, {28'h0, r.g});
        chk("run_len", run_len, r.len);
      end
      run_len = 0;
    end
    if (done) done_cnt++;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 1;
    while (!done && lat < 3000) begin
      cyc();
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, lat);
    end
  endtask

  task automatic pulse_start();
    done_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic post_scan(input string name);
    repeat (3) cyc();
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_busy"}, {31'h0, busy}, 0);
    chk({name, "_gate_cur"}, {28'h0, gate_cur}, 0);
    chk({name, "_addr_idle"}, {24'h0, bus_addr}, 0);
    chk({name, "_err_cnt"}, {24'h0, err_cnt}, exp_err);
    chk({name, "_wr_left"}, exp_wr.size(), 0);
    chk({name, "_run_left"}, exp_run.size(), 0);
  endtask

  task automatic run_scan(input vec_t v);
    logic [3:0] g;
    int lat;
    mask = v.mask; dwell = v.dwell; reject = v.reject; loop = 1'b0;
    for (int k = 0; k < v.nseq; k++) begin
      g = v.seq[4*k +: 4];
      exp_wr.push_back({4'h0, g});
      if (!v.reject[g]) exp_run.push_back('{g, (v.dwell == 0) ? 1 : int'(v.dwell)});
    end
    exp_wr.push_back(8'h00);
    exp_err = (exp_err + v.err_inc > 255) ? 255 : exp_err + v.err_inc;
    pulse_start();
    wait_done("scan", lat);
    chk("scan_latency", lat, v.lat);
    post_scan("scan");
  endtask

  task automatic push_runs(input int first, input int last, input int len);
    for (int gg = first; gg <= last; gg++) begin
      exp_wr.push_back(8'(gg));
      exp_run.push_back('{4'(gg), len});
    end
  endtask

  initial begin
    int lat;
    int t;
    vecs[0] = '{mask: 10'h000, dwell: 16'd3, reject: 16'h0000, seq: 40'hA987654321, nseq: 10, err_inc: 0, lat: 83};
    vecs[1] = '{mask: 10'h005, dwell: 16'd3, reject: 16'h0000, seq: 40'h00A9876542, nseq: 8,  err_inc: 0, lat: 69};
    vecs[2] = '{mask: 10'h000, dwell: 16'd2, reject: 16'h0020, seq: 40'hA987654321, nseq: 10, err_inc: 1, lat: 71};
    vecs[3] = '{mask: 10'h3FF, dwell: 16'd1, reject: 16'h0000, seq: 40'h0,          nseq: 0,  err_inc: 0, lat: 12};
    vecs[4] = '{mask: 10'h3FE, dwell: 16'd0, reject: 16'h0000, seq: 40'h1,          nseq: 1,  err_inc: 0, lat: 18};
    vecs[5] = '{mask: 10'h1FF, dwell: 16'd5, reject: 16'h0000, seq: 40'hA,          nseq: 1,  err_inc: 0, lat: 22};

    cyc();
    chk("rst_addr", {24'h0, bus_addr}, 0);
    chk("rst_wdata", {24'h0, bus_wdata}, 0);
    chk("rst_we", {31'h0, bus_we}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_valid", {31'h0, gate_valid}, 0);
    chk("rst_err", {24'h0, err_cnt}, 0);
    res_n = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) run_scan(vecs[i]);

    // start and stop together while idle: start ignored
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", {31'h0, busy}, 0);
    cyc();
    chk("startstop_busy2", {31'h0, busy}, 0);

    // loop with dwell 0, dropped during the second pass
    mask = '0; dwell = '0; reject = '0; loop = 1'b1;
    push_runs(1, 10, 1);
    push_runs(1, 10, 1);
    exp_wr.push_back(8'h00);
    n_wr = 0;
    pulse_start();
    t = 0;
    while (n_wr < 13 && t < 500) begin cyc(); t++; end
    chk("loop_reached_pass2", {31'h0, (n_wr >= 13)}, 1);
    loop = 1'b0;
    wait_done("loop", lat);
    post_scan("loop");

    // stop during DWELL of gate 4
    dwell = 16'd5;
    push_runs(1, 3, 5);
    exp_wr.push_back(8'd4);
    exp_run.push_back('{4'd4, 1});
    exp_wr.push_back(8'h00);
    pulse_start();
    t = 0;
    while (!(gate_valid && gate_cur == 4'd4) && t < 500) begin cyc(); t++; end
    chk("stopdw_reached", {31'h0, gate_valid}, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stopdw_park_we", {31'h0, bus_we}, 1);
    chk("stopdw_park_wdata", {24'h0, bus_wdata}, 0);
    chk("stopdw_valid", {31'h0, gate_valid}, 0);
    cyc();
    chk("stopdw_done", {31'h0, done}, 1);
    post_scan("stopdw");

    // stop during WAIT1 of gate 2
    dwell = 16'd2;
    push_runs(1, 1, 2);
    exp_wr.push_back(8'd2);
    exp_wr.push_back(8'h00);
    pulse_start();
    t = 0;
    while (!(bus_we && gate_cur == 4'd2) && t < 500) begin cyc(); t++; end
    cyc();
    chk("stopw1_wait_we", {31'h0, bus_we}, 0);
    chk("stopw1_wait_addr", {24'h0, bus_addr}, 32'h22);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stopw1_park_we", {31'h0, bus_we}, 1);
    chk("stopw1_park_gate", {28'h0, gate_cur}, 0);
    cyc();
    chk("stopw1_done", {31'h0, done}, 1);
    post_scan("stopw1");

    // every gate rejected with loop: error counter saturates at 255
    sb_en = 1'b0;
    dwell = 16'd1; reject = 16'hFFFE; loop = 1'b1;
    pulse_start();
    repeat (1550) cyc();
    chk("sat_err_255", {24'h0, err_cnt}, 255);
    chk("sat_busy", {31'h0, busy}, 1);
    repeat (200) cyc();
    chk("sat_err_hold", {24'h0, err_cnt}, 255);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    wait_done("sat", lat);
    repeat (3) cyc();
    reject = '0; loop = 1'b0;
    sb_en = 1'b1;
    exp_err = 255;

    // asynchronous reset during DWELL of gate 3, then a fresh scan
    dwell = 16'd10;
    exp_run.push_back('{4'd1, 10});
    exp_run.push_back('{4'd2, 10});
    sb_en = 1'b0;
    pulse_start();
    t = 0;
    while (!(gate_valid && gate_cur == 4'd3) && t < 500) begin cyc(); t++; end
    chk("rstdw_reached", {31'h0, gate_valid}, 1);
    res_n = 1'b0;
    #1;
    chk("rstdw_valid", {31'h0, gate_valid}, 0);
    chk("rstdw_busy", {31'h0, busy}, 0);
    chk("rstdw_gate", {28'h0, gate_cur}, 0);
    chk("rstdw_addr", {24'h0, bus_addr}, 0);
    chk("rstdw_we", {31'h0, bus_we}, 0);
    chk("rstdw_err", {24'h0, err_cnt}, 0);
    run_len = 0;
    exp_wr.delete();
    exp_run.delete();
    cyc();
    res_n = 1'b1;
    cyc();
    sb_en = 1'b1;
    exp_err = 0;
    run_scan(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
